// File: rtl/ebus_xfer_ctl.sv
// EBUS transfer sequencer: setup, demand/XFER handshake, hold, release and done, with no-device timeout.
// Optional EBUS parity generation/checking is compiled in when EBUS_PARITY_EN is defined.
module ebus_xfer_ctl #(
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic        start,
  input  logic        dirOut,
  input  logic [0:2]  func,
  input  logic [0:6]  dev,
  input  logic        ebusXferIn,
  input  logic [0:35] adData,
  input  logic [0:35] ebusData,
  input  logic        ebusParityIn,
  output logic        busy,
  output logic        done,
  output logic        timeoutErr,
  output logic        parityErr,
  output logic [0:2]  ebusFunc,
  output logic [0:6]  ebusDev,
  output logic        ebusDemand,
  output logic        adToEbusL,
  output logic        adToEbusR,
  output logic        tToEEn,
  output logic        eToTEn,
  output logic        arLoad,
  output logic        ebusParityOut
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DEMAND,
    HOLD,
    RELEASE,
    DONE
  } state_t;

  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT_CYC - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       dir_q, dir_nxt;
  logic [0:2] func_nxt;
  logic [0:6] dev_nxt;
  logic       tmo_nxt;
  logic       ar_nxt;
  logic       busy_nxt, done_nxt, demand_nxt, ad_nxt, en_nxt;
  logic       accept;

  // Next-state logic; every registered output is decoded from the next state
  // so that the outputs line up exactly with the state they describe.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    func_nxt  = ebusFunc;
    dev_nxt   = ebusDev;
    tmo_nxt   = timeoutErr;
    ar_nxt    = 1'b0;
    accept    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          dir_nxt   = dirOut;
          func_nxt  = func;
          dev_nxt   = dev;
          tmo_nxt   = 1'b0;
          cnt_nxt   = SETUP_LD;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          cnt_nxt   = TIMEOUT_LD;
          state_nxt = DEMAND;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      DEMAND: begin
        // XFER wins over a coincident expiry of the timeout counter.
        if (ebusXferIn) begin
          cnt_nxt   = HOLD_LD;
          ar_nxt    = ~dir_q;
          state_nxt = HOLD;
        end else if (cnt == 8'd0) begin
          tmo_nxt   = 1'b1;
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      RELEASE: begin
        if (!ebusXferIn) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt   = (state_nxt != IDLE);
    done_nxt   = (state_nxt == DONE);
    demand_nxt = (state_nxt == DEMAND) || (state_nxt == HOLD);
    en_nxt     = (state_nxt == SETUP) || (state_nxt == DEMAND) ||
                 (state_nxt == HOLD)  || (state_nxt == RELEASE);
    ad_nxt     = dir_nxt && ((state_nxt == SETUP) || (state_nxt == DEMAND) ||
                             (state_nxt == HOLD));
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      dir_q      <= 1'b0;
      ebusFunc   <= 3'd0;
      ebusDev    <= 7'd0;
      timeoutErr <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ebusDemand <= 1'b0;
      adToEbusL  <= 1'b0;
      adToEbusR  <= 1'b0;
      tToEEn     <= 1'b0;
      eToTEn     <= 1'b0;
      arLoad     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dir_q      <= dir_nxt;
      ebusFunc   <= func_nxt;
      ebusDev    <= dev_nxt;
      timeoutErr <= tmo_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      ebusDemand <= demand_nxt;
      adToEbusL  <= ad_nxt;
      adToEbusR  <= ad_nxt;
      tToEEn     <= en_nxt && dir_nxt;
      eToTEn     <= en_nxt && !dir_nxt;
      arLoad     <= ar_nxt;
    end
  end

`ifdef EBUS_PARITY_EN
  logic par_out_nxt, par_err_nxt;

  // Read data is checked for odd parity in the same cycle AR is loaded from the bus.
  always_comb begin
    par_err_nxt = parityErr;
    if (accept) begin
      par_err_nxt = 1'b0;
    end else if (arLoad && ((^ebusData ^ ebusParityIn) != 1'b1)) begin
      par_err_nxt = 1'b1;
    end
    par_out_nxt = ad_nxt ? ~^adData : 1'b0;
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      parityErr     <= 1'b0;
      ebusParityOut <= 1'b0;
    end else begin
      parityErr     <= par_err_nxt;
      ebusParityOut <= par_out_nxt;
    end
  end
`else
  logic unused_parity_inputs;

  assign unused_parity_inputs = ^{adData, ebusData, ebusParityIn, accept};
  assign parityErr            = 1'b0;
  assign ebusParityOut        = 1'b0;
`endif

endmodule

// File: tb/tb_ebus_xfer_ctl.sv
// Self-checking bench for ebus_xfer_ctl: directed and randomized transfers checked every cycle
// against a timeline model derived from the transfer parameters (honours EBUS_PARITY_EN).
module tb_ebus_xfer_ctl;

  localparam int S = 2;
  localparam int H = 2;
  localparam int T = 64;

  logic        clk = 1'b0;
  logic        CROBAR;
  logic        start;
  logic        dirOut;
  logic [0:2]  func;
  logic [0:6]  dev;
  logic        ebusXferIn;
  logic [0:35] adData;
  logic [0:35] ebusData;
  logic        ebusParityIn;
  logic        busy, done, timeoutErr, parityErr;
  logic [0:2]  ebusFunc;
  logic [0:6]  ebusDev;
  logic        ebusDemand, adToEbusL, adToEbusR, tToEEn, eToTEn, arLoad, ebusParityOut;

  int checks = 0;
  int errors = 0;

  // Current transfer description and its derived timeline (cycle 1 = first cycle after start edge)
  logic        tDir;
  logic [0:2]  tFunc;
  logic [0:6]  tDev;
  bit          tTimeout;
  int          tD, tR;
  logic [0:35] tAd, tEd;
  logic        tEp;
  int          ds, rel, doneCyc, arCyc;

  ebus_xfer_ctl #(.SETUP_CYC(S), .HOLD_CYC(H), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .CROBAR(CROBAR), .start(start), .dirOut(dirOut), .func(func), .dev(dev),
    .ebusXferIn(ebusXferIn), .adData(adData), .ebusData(ebusData), .ebusParityIn(ebusParityIn),
    .busy(busy), .done(done), .timeoutErr(timeoutErr), .parityErr(parityErr),
    .ebusFunc(ebusFunc), .ebusDev(ebusDev), .ebusDemand(ebusDemand),
    .adToEbusL(adToEbusL), .adToEbusR(adToEbusR), .tToEEn(tToEEn), .eToTEn(eToTEn),
    .arLoad(arLoad), .ebusParityOut(ebusParityOut)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset();
    cmp("rst_busy", 64'(busy), 64'd0);
    cmp("rst_done", 64'(done), 64'd0);
    cmp("rst_tmo", 64'(timeoutErr), 64'd0);
    cmp("rst_perr", 64'(parityErr), 64'd0);
    cmp("rst_func", 64'(ebusFunc), 64'd0);
    cmp("rst_dev", 64'(ebusDev), 64'd0);
    cmp("rst_demand", 64'(ebusDemand), 64'd0);
    cmp("rst_adl", 64'(adToEbusL), 64'd0);
    cmp("rst_adr", 64'(adToEbusR), 64'd0);
    cmp("rst_tte", 64'(tToEEn), 64'd0);
    cmp("rst_ett", 64'(eToTEn), 64'd0);
    cmp("rst_arload", 64'(arLoad), 64'd0);
    cmp("rst_pout", 64'(ebusParityOut), 64'd0);
  endtask

  task automatic checkOutput(input int c);
    logic expBusy, expDone, expDem, expTte, expEtt, expAd, expAr, expTmo, expPo, expPe;
    expBusy = (c >= 1) && (c <= doneCyc);
    expDone = (c == doneCyc);
    expDem  = (c >= ds) && (c < rel);
    expTte  = tDir && (c >= 1) && (c < doneCyc);
    expEtt  = !tDir && (c >= 1) && (c < doneCyc);
    expAd   = tDir && (c >= 1) && (c < rel);
    expAr   = !tDir && !tTimeout && (c == arCyc);
    expTmo  = tTimeout && (c >= rel);
`ifdef EBUS_PARITY_EN
    expPo   = expAd ? ~^tAd : 1'b0;
    expPe   = !tDir && !tTimeout && (c > arCyc) && ((^tEd ^ tEp) != 1'b1);
`else
    expPo   = 1'b0;
    expPe   = 1'b0;
`endif
    cmp($sformatf("busy@%0d", c), 64'(busy), 64'(expBusy));
    cmp($sformatf("done@%0d", c), 64'(done), 64'(expDone));
    cmp($sformatf("demand@%0d", c), 64'(ebusDemand), 64'(expDem));
    cmp($sformatf("tToEEn@%0d", c), 64'(tToEEn), 64'(expTte));
    cmp($sformatf("eToTEn@%0d", c), 64'(eToTEn), 64'(expEtt));
    cmp($sformatf("adToEbusL@%0d", c), 64'(adToEbusL), 64'(expAd));
    cmp($sformatf("adToEbusR@%0d", c), 64'(adToEbusR), 64'(expAd));
    cmp($sformatf("arLoad@%0d", c), 64'(arLoad), 64'(expAr));
    cmp($sformatf("timeoutErr@%0d", c), 64'(timeoutErr), 64'(expTmo));
    cmp($sformatf("ebusFunc@%0d", c), 64'(ebusFunc), 64'(tFunc));
    cmp($sformatf("ebusDev@%0d", c), 64'(ebusDev), 64'(tDev));
    cmp($sformatf("parityOut@%0d", c), 64'(ebusParityOut), 64'(expPo));
    cmp($sformatf("parityErr@%0d", c), 64'(parityErr), 64'(expPe));
  endtask

  // d: cycles after demand rises before XFER rises (d >= T means the device never answers)
  // r: cycles after demand falls before XFER drops
  task automatic applyStimulus(input logic dir, input logic [0:2] f, input logic [0:6] dv,
                               input int d, input int r, input bit noise,
                               input logic [0:35] ad, input logic [0:35] ed, input logic ep);
    tDir = dir; tFunc = f; tDev = dv; tD = d; tR = r;
    tAd = ad; tEd = ed; tEp = ep;
    tTimeout = (d >= T);
    ds = S + 1;
    if (!tTimeout) begin
      arCyc   = ds + d + 1;
      rel     = ds + d + 1 + H;
      doneCyc = rel + r + 1;
    end else begin
      arCyc   = -1;
      rel     = ds + T;
      doneCyc = rel + 1;
    end
    dirOut = dir; func = f; dev = dv;
    adData = ad; ebusData = ed; ebusParityIn = ep;
    ebusXferIn = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= doneCyc + 1; c++) begin
      checkOutput(c);
      start = 1'b0; dirOut = tDir; func = tFunc; dev = tDev;
      if (noise && (c <= doneCyc) && ($urandom_range(0, 3) == 0)) begin
        start  = 1'b1;
        dirOut = 1'($urandom_range(0, 1));
        func   = 3'($urandom);
        dev    = 7'($urandom);
      end
      if (c <= S) ebusXferIn = 1'($urandom_range(0, 1));
      else if (tTimeout) ebusXferIn = 1'b0;
      else ebusXferIn = (c >= ds + tD) && (c < rel + tR);
      @(posedge clk); #1;
    end
    start = 1'b0; ebusXferIn = 1'b0;
    dirOut = tDir; func = tFunc; dev = tDev;
  endtask

  initial begin
    CROBAR = 1'b1; start = 1'b0; dirOut = 1'b0; func = 3'd0; dev = 7'd0;
    ebusXferIn = 1'b0; adData = 36'd0; ebusData = 36'd0; ebusParityIn = 1'b0;
    #3;
    checkReset();
    @(negedge clk);
    CROBAR = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed write, XFER 3 cycles after demand");
    applyStimulus(1'b1, 3'b011, 7'o12, 3, 1, 1'b0, 36'o1, 36'd0, 1'b0);

    $display("[TB] directed read, XFER waiting, minimum latency");
    applyStimulus(1'b0, 3'b101, 7'o40, 0, 0, 1'b0, 36'd0, 36'd0, 1'b1);

    $display("[TB] no device, timeout");
    applyStimulus(1'b0, 3'b110, 7'o77, T + 10, 0, 1'b0, 36'd0, 36'd0, 1'b1);

    $display("[TB] XFER coincident with expiry, start noise while busy");
    applyStimulus(1'b1, 3'b001, 7'o05, T - 1, 2, 1'b1, 36'o777, 36'd0, 1'b0);

    $display("[TB] parity reads");
    applyStimulus(1'b0, 3'b010, 7'o11, 2, 1, 1'b0, 36'd0, 36'd0, 1'b0);
    applyStimulus(1'b0, 3'b010, 7'o11, 2, 1, 1'b0, 36'd0, 36'd0, 1'b1);

    $display("[TB] reset mid-DEMAND");
    dirOut = 1'b1; func = 3'b111; dev = 7'o55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    cmp("pre_reset_demand", 64'(ebusDemand), 64'd1);
    CROBAR = 1'b1;
    #1;
    checkReset();
    CROBAR = 1'b0;
    #1;
    applyStimulus(1'b0, 3'b100, 7'o21, 1, 0, 1'b0, 36'd0, 36'o3, 1'b1);

    $display("[TB] randomized transfers");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom), 7'($urandom),
                    int'($urandom_range(0, T + 5)), int'($urandom_range(0, 3)), 1'b1,
                    36'({$urandom, $urandom}), 36'({$urandom, $urandom}),
                    1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
